// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, bit-timing helper and the
// ASCII codes shared with the downstream sequence checker.
package uart_pkg;

   typedef enum logic [4:0] {
      ST_IDLE   = 5'b00001,
      ST_START  = 5'b00010,
      ST_DATA   = 5'b00100,
      ST_PARITY = 5'b01000,
      ST_STOP   = 5'b10000
   } rx_state_e;

   localparam logic [7:0] ASCII_H = 8'h68;
   localparam logic [7:0] ASCII_E = 8'h65;
   localparam logic [7:0] ASCII_L = 8'h6C;
   localparam logic [7:0] ASCII_O = 8'h6F;

   // sys_clk cycles per bit period
   function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                              input int unsigned baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer plus one-cycle delay and falling-edge detect for an
// asynchronous, idle-high input line.
module uart_rx_sync (
   input  logic sys_clk,
   input  logic reset_n,
   input  logic d_i,
   output logic level_o,
   output logic fall_c
);

   logic rx_s1_q;
   logic rx_s2_q;
   logic rx_s3_q;

   // Reset to low so a line already low at reset release is not seen as an edge
   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         rx_s1_q <= 1'b0;
         rx_s2_q <= 1'b0;
         rx_s3_q <= 1'b0;
      end else begin
         rx_s1_q <= d_i;
         rx_s2_q <= rx_s1_q;
         rx_s3_q <= rx_s2_q;
      end
   end

   assign level_o = rx_s2_q;
   assign fall_c  = rx_s3_q & ~rx_s2_q;

endmodule

// File: rtl/uart_byte_rx.sv
// UART byte receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 with a
// parity_err strobe.
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned BAUD     = 115200
) (
   input  logic       sys_clk,
   input  logic       reset_n,
   input  logic       uart_rxd,
   output logic [7:0] data_out,
   output logic       data_out_valid,
   output logic       frame_err
`ifdef UART_RX_PARITY_EN
   ,
   output logic       parity_err
`endif
);

   localparam int unsigned BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD);
   localparam int unsigned CNT_W      = $clog2(BIT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(BIT_CYCLES / 2 - 1);

   if (BIT_CYCLES < 4) begin : g_bit_cycles_check
      $error("uart_byte_rx: BIT_CYCLES must be at least 4");
   end

   logic rx_s2;
   logic start_edge;

   uart_rx_sync u_sync (
      .sys_clk (sys_clk),
      .reset_n (reset_n),
      .d_i     (uart_rxd),
      .level_o (rx_s2),
      .fall_c  (start_edge)
   );

   rx_state_e        state_q;
   logic [CNT_W-1:0] bit_cnt_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shreg_q;
   logic [7:0]       data_q;
   logic             valid_q;
   logic             ferr_q;
`ifdef UART_RX_PARITY_EN
   logic             par_bad_q;
   logic             perr_q;
`endif

   logic sample;
   logic wrap;
   assign sample = (bit_cnt_q == CNT_SAMPLE);
   assign wrap   = (bit_cnt_q == CNT_LAST);

   // Frame FSM; the stop state exits at mid-bit so the next start edge is never missed
   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q  <= 1'b0;
`endif
         if (state_q != ST_IDLE) begin
            bit_cnt_q <= wrap ? '0 : bit_cnt_q + CNT_W'(1);
         end
         case (state_q)
            ST_IDLE: begin
               bit_cnt_q <= '0;
               if (start_edge) begin
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               if (sample && rx_s2) begin
                  state_q   <= ST_IDLE;
                  bit_cnt_q <= '0;
               end else if (wrap) begin
                  state_q   <= ST_DATA;
                  bit_idx_q <= '0;
               end
            end
            ST_DATA: begin
               if (sample) begin
                  shreg_q <= {rx_s2, shreg_q[7:1]};
               end
               if (wrap) begin
                  if (bit_idx_q == 3'd7) begin
                     bit_idx_q <= '0;
`ifdef UART_RX_PARITY_EN
                     state_q   <= ST_PARITY;
`else
                     state_q   <= ST_STOP;
`endif
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (sample) begin
                  par_bad_q <= rx_s2 ^ (^shreg_q);
               end
               if (wrap) begin
                  state_q <= ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               if (sample) begin
                  state_q   <= ST_IDLE;
                  bit_cnt_q <= '0;
                  if (rx_s2) begin
                     data_q  <= shreg_q;
                     valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     perr_q  <= par_bad_q;
`endif
                  end else begin
                     ferr_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               bit_cnt_q <= '0;
            end
         endcase
      end
   end

   assign data_out       = data_q;
   assign data_out_valid = valid_q;
   assign frame_err      = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err     = perr_q;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx at 16 clocks per bit.
module tb_uart_byte_rx;
   import uart_pkg::*;

   localparam int BC = 16;
`ifdef UART_RX_PARITY_EN
   localparam int LAT = 9 * BC + BC / 2 + 1 + BC;
`else
   localparam int LAT = 9 * BC + BC / 2 + 1;
`endif
   localparam int SYNC = 2;

   logic       sys_clk = 1'b0;
   logic       reset_n;
   logic       uart_rxd;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       frame_err;
   logic       perr_w;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
   assign perr_w = parity_err;
`else
   assign perr_w = 1'b0;
`endif

   uart_byte_rx #(.CLK_FREQ(16), .BAUD(1)) dut (
      .sys_clk        (sys_clk),
      .reset_n        (reset_n),
      .uart_rxd       (uart_rxd),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .frame_err      (frame_err)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err     (parity_err)
`endif
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       pflip;
      int         gap;
      logic       exp_valid;
      logic       exp_ferr;
      logic       exp_perr;
      logic [7:0] exp_data;
   } vec_t;

   typedef struct {
      logic       valid;
      logic       ferr;
      logic       perr;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic send_bits(input logic b, input int n);
      uart_rxd = b;
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
      send_bits(1'b0, BC);
      for (int i = 0; i < 8; i++) send_bits(d[i], BC);
`ifdef UART_RX_PARITY_EN
      send_bits((^d) ^ pflip, BC);
`else
      if (pflip) begin end
`endif
      send_bits(stop, BC);
   endtask

   // Scoreboard: every output pulse must match the oldest expected event
   always @(negedge sys_clk) begin
      if (reset_n === 1'b1 && (data_out_valid || frame_err || perr_w)) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: valid=%0b ferr=%0b perr=%0b at cycle %0d, required no pulse",
                     data_out_valid, frame_err, perr_w, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("pulse_valid", 32'(data_out_valid), 32'(e.valid));
            check("pulse_ferr", 32'(frame_err), 32'(e.ferr));
            check("pulse_data", 32'(data_out), 32'(e.data));
            check("pulse_cycle", 32'(cyc), 32'(e.cyc));
`ifdef UART_RX_PARITY_EN
            check("pulse_perr", 32'(parity_err), 32'(e.perr));
`endif
         end
      end
   end

   vec_t vecs[13];

   task automatic push_exp(input vec_t v);
      exp_t e;
      e.valid = v.exp_valid;
      e.ferr  = v.exp_ferr;
      e.perr  = v.exp_perr;
      e.data  = v.exp_data;
      e.cyc   = cyc + SYNC + LAT;
      if (v.exp_valid || v.exp_ferr) sb.push_back(e);
   endtask

   initial begin
      //           data     stop  pflip gap valid ferr perr  exp_data
      vecs[0]  = '{ASCII_H, 1'b1, 1'b0, 30, 1'b1, 1'b0, 1'b0, 8'h68};
      vecs[1]  = '{ASCII_H, 1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b0, 8'h68};
      vecs[2]  = '{ASCII_E, 1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b0, 8'h65};
      vecs[3]  = '{ASCII_L, 1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b0, 8'h6C};
      vecs[4]  = '{ASCII_L, 1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b0, 8'h6C};
      vecs[5]  = '{ASCII_O, 1'b1, 1'b0, 30, 1'b1, 1'b0, 1'b0, 8'h6F};
      vecs[6]  = '{8'h55,   1'b0, 1'b0, 30, 1'b0, 1'b1, 1'b0, 8'h6F};
      vecs[7]  = '{ASCII_O, 1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b0, 8'h6F};
      vecs[8]  = '{ASCII_L, 1'b1, 1'b1, 0,  1'b1, 1'b0, 1'b1, 8'h6C};
      vecs[9]  = '{8'h00,   1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b0, 8'h00};
      vecs[10] = '{8'hFF,   1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b0, 8'hFF};
      vecs[11] = '{8'h80,   1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b0, 8'h80};
      vecs[12] = '{8'h01,   1'b1, 1'b0, 30, 1'b1, 1'b0, 1'b0, 8'h01};

      reset_n  = 1'b0;
      uart_rxd = 1'b1;
      repeat (3) @(negedge sys_clk);
      check("reset_data", 32'(data_out), 32'h00);
      check("reset_valid", 32'(data_out_valid), 32'h0);
      check("reset_ferr", 32'(frame_err), 32'h0);
      check("reset_perr", 32'(perr_w), 32'h0);
      check("reset_state", 32'(dut.state_q), 32'(ST_IDLE));
      reset_n = 1'b1;
      repeat (5) @(negedge sys_clk);

      for (int i = 0; i < 13; i++) begin
         push_exp(vecs[i]);
         send_frame(vecs[i].data, vecs[i].stop, vecs[i].pflip);
         send_bits(1'b1, vecs[i].gap);
      end

      // Four-cycle low glitch: start is rejected at the start-bit sample point
      begin
         int c0;
         c0 = cyc;
         send_bits(1'b0, 4);
         send_bits(1'b1, 6);
         check("glitch_in_start", 32'(cyc - c0), 32'd10);
         check("glitch_state_start", 32'(dut.state_q), 32'(ST_START));
         @(negedge sys_clk);
         check("glitch_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
         send_bits(1'b1, 200);
      end

      // One-cycle reset in the middle of data bit 3 of 0xF8
      send_bits(1'b0, BC);
      for (int i = 0; i < 3; i++) send_bits(1'b0, BC);
      send_bits(1'b1, BC / 2);
      reset_n = 1'b0;
      @(negedge sys_clk);
      check("midreset_data", 32'(data_out), 32'h00);
      check("midreset_valid", 32'(data_out_valid), 32'h0);
      check("midreset_ferr", 32'(frame_err), 32'h0);
      check("midreset_perr", 32'(perr_w), 32'h0);
      check("midreset_state", 32'(dut.state_q), 32'(ST_IDLE));
      reset_n = 1'b1;
      send_bits(1'b1, BC / 2 - 1 + 6 * BC + 40);

      begin
         vec_t v;
         v = '{8'h3C, 1'b1, 1'b0, 30, 1'b1, 1'b0, 1'b0, 8'h3C};
         push_exp(v);
         send_frame(v.data, v.stop, v.pflip);
         send_bits(1'b1, 250);
      end

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
